// File: rtl/mkio_bus_switch.sv
// Redundant MKIO line switch: synchronises N_CH line pairs, locks onto the first
// active healthy channel, routes it to the receiver and steers transmit back onto it.
module mkio_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d1,
  input  logic d0,
  output logic q1,
  output logic q0
);
  logic m1, m0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= 1'b0; m0 <= 1'b0; q1 <= 1'b0; q0 <= 1'b0;
    end else begin
      m1 <= d1; m0 <= d0; q1 <= m1; q0 <= m0;
    end
  end
endmodule

module mkio_bus_switch #(
  parameter int N_CH       = 2,
  parameter int HOLD       = 5,
  parameter int IDLE_CYC   = 64,
  parameter int BABBLE_CYC = 1600
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         di1,
  input  logic [N_CH-1:0]         di0,
  output logic [N_CH-1:0]         do1,
  output logic [N_CH-1:0]         do0,
  output logic [N_CH-1:0]         rx_strob,
  output logic [N_CH-1:0]         tx_inhibit,
  output logic                    rx_di1,
  output logic                    rx_di0,
  input  logic                    tx_do1,
  input  logic                    tx_do0,
  input  logic                    tx_busy,
  output logic [$clog2(N_CH)-1:0] sel_ch,
  output logic                    active,
  output logic [N_CH-1:0]         ch_fault,
  input  logic [N_CH-1:0]         fault_clr
);
  localparam int SW = $clog2(N_CH);
  localparam int QW = $clog2(IDLE_CYC + 1);
  localparam int BW = $clog2(BABBLE_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_RX, S_TX, S_HOLD} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   sel_nxt, pick;
  logic            found;
  logic [N_CH-1:0] s_di1, s_di0, act, fault_set, fault_nxt, sel_oh, tx_own;
  logic [QW-1:0]   quiet_cnt;
  logic [BW-1:0]   babble_cnt;
  logic [7:0]      hold_cnt;
  logic            act_sel, rx_en, do_en;

  mkio_sync2 u_sync [N_CH-1:0] (
    .clk(clk), .rst(rst), .d1(di1), .d0(di0), .q1(s_di1), .q0(s_di0)
  );

  assign act     = s_di1 | s_di0;
  assign act_sel = act[sel_ch];

  // Descending scan so the lowest eligible channel wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (act[i] && !ch_fault[i]) begin
        pick  = SW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_ch;
    fault_set = '0;
    case (state)
      S_IDLE: begin
        if (tx_busy) state_nxt = S_TX;
        else if (found) begin
          sel_nxt   = pick;
          state_nxt = S_RX;
        end
      end
      S_RX: begin
        if (tx_busy) state_nxt = S_TX;
        else if (act_sel) begin
          if (babble_cnt == BW'(BABBLE_CYC - 1)) begin
            fault_set[sel_ch] = 1'b1;
            state_nxt         = S_IDLE;
          end
        end else if (quiet_cnt == QW'(IDLE_CYC - 1)) state_nxt = S_IDLE;
      end
      S_TX:    if (!tx_busy) state_nxt = S_HOLD;
      S_HOLD: begin
        if (tx_busy) state_nxt = S_TX;
        else if (hold_cnt == 8'd1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  assign fault_nxt = (ch_fault & ~fault_clr) | fault_set;
  assign sel_oh    = N_CH'(1) << sel_nxt;
  assign tx_own    = (state_nxt == S_TX || state_nxt == S_HOLD) ? sel_oh : '0;
  assign rx_en     = (state_nxt == S_RX);
  assign do_en     = (state_nxt == S_TX) && !fault_nxt[sel_nxt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sel_ch     <= '0;
      quiet_cnt  <= '0;
      babble_cnt <= '0;
      hold_cnt   <= '0;
      ch_fault   <= '0;
      do1        <= '0;
      do0        <= '0;
      rx_di1     <= 1'b0;
      rx_di0     <= 1'b0;
      active     <= 1'b0;
      rx_strob   <= '1;
      tx_inhibit <= '1;
    end else begin
      state      <= state_nxt;
      sel_ch     <= sel_nxt;
      ch_fault   <= fault_nxt;
      quiet_cnt  <= (state == S_RX && !act_sel) ? quiet_cnt + 1'b1 : '0;
      babble_cnt <= (state == S_RX && act_sel) ? babble_cnt + 1'b1 : '0;
      if (state_nxt == S_HOLD && state != S_HOLD) hold_cnt <= 8'(HOLD);
      else if (state == S_HOLD)                   hold_cnt <= hold_cnt - 1'b1;
      rx_di1     <= rx_en & s_di1[sel_nxt];
      rx_di0     <= rx_en & s_di0[sel_nxt];
      do1        <= {N_CH{tx_do1 & do_en}} & sel_oh;
      do0        <= {N_CH{tx_do0 & do_en}} & sel_oh;
      rx_strob   <= ~fault_nxt & ~tx_own;
      tx_inhibit <= ~tx_own;
      active     <= (state_nxt != S_IDLE);
    end
  end
endmodule
